// File: rtl/mips_isa_pkg.sv
// Shared MIPS-subset ISA definitions: mnemonic codes, opcode/funct values and
// instruction field positions, common to the instruction encoder and a decoder.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDU = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_ADDI = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_J    = 4'd8
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;

  // Least-significant bit of each field within the 32-bit instruction word.
  localparam int unsigned OPC_LSB   = 32'd26;
  localparam int unsigned RS_LSB    = 32'd21;
  localparam int unsigned RT_LSB    = 32'd16;
  localparam int unsigned RD_LSB    = 32'd11;
  localparam int unsigned SHAMT_LSB = 32'd6;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_J);
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational field-to-word encoder for the MIPS-subset mnemonics; any
// illegal mnemonic code encodes to an all-zero word.
module instr_field_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] adr_i,
  output logic [31:0] word_o
);

  logic [31:0] regs_s;
  logic [31:0] rtype_s;
  logic [31:0] itype_s;

  // Field placement shared by the R and I formats.
  always_comb begin
    regs_s  = (32'(rs_i) << RS_LSB) | (32'(rt_i) << RT_LSB);
    rtype_s = (32'(OPC_RTYPE) << OPC_LSB) | regs_s
            | (32'(rd_i) << RD_LSB) | (32'(shamt_i) << SHAMT_LSB);
    itype_s = regs_s | 32'(imm_i);
  end

  // Opcode / funct selection per mnemonic.
  always_comb begin
    word_o = 32'h0000_0000;
    case (op_i)
      OP_ADD:  word_o = rtype_s | 32'(FUNCT_ADD);
      OP_ADDU: word_o = rtype_s | 32'(FUNCT_ADDU);
      OP_SUB:  word_o = rtype_s | 32'(FUNCT_SUB);
      OP_AND:  word_o = rtype_s | 32'(FUNCT_AND);
      OP_ADDI: word_o = (32'(OPC_ADDI) << OPC_LSB) | itype_s;
      OP_LW:   word_o = (32'(OPC_LW) << OPC_LSB) | itype_s;
      OP_SW:   word_o = (32'(OPC_SW) << OPC_LSB) | itype_s;
      OP_BEQ:  word_o = (32'(OPC_BEQ) << OPC_LSB) | itype_s;
      OP_J:    word_o = (32'(OPC_J) << OPC_LSB) | 32'(adr_i);
      default: word_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction loader: encodes MIPS-subset fields and writes them to instruction
// memory from base_addr onward. Define ENC_ILLEGAL_CHECK_EN to reject illegal ops.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               op,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [15:0]              imm,
  input  logic [25:0]              adr,
  output logic                     imem_we,
  output logic [$clog2(DEPTH)-1:0] imem_addr,
  output logic [31:0]              imem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(32'd1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] base_q, base_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [31:0]   enc_word_s;
  logic          xfer_s;
  logic          reject_s;

  instr_field_encoder u_enc (
    .op_i    (op),
    .rs_i    (rs),
    .rt_i    (rt),
    .rd_i    (rd),
    .shamt_i (shamt),
    .imm_i   (imm),
    .adr_i   (adr),
    .word_o  (enc_word_s)
  );

`ifdef ENC_ILLEGAL_CHECK_EN
  assign reject_s = !op_is_legal(op);
`else
  assign reject_s = 1'b0;
`endif

  assign in_ready = (state_q == ST_LOAD) && !start;
  assign xfer_s   = in_valid && in_ready;

  // Next-state: session restart, rejected transfer, or accepted transfer.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    base_d  = base_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    if (start) begin
      state_d = ST_LOAD;
      count_d = {(AW+1){1'b0}};
      base_d  = base_addr;
    end else if (xfer_s && reject_s) begin
      err_d = 1'b1;
    end else if (xfer_s) begin
      // Address is captured now so a restart next cycle cannot move this write.
      we_d    = 1'b1;
      addr_d  = base_q + count_q[AW-1:0];
      wdata_d = enc_word_s;
      count_d = count_q + CNT_ONE;
      if (count_q == CNT_LAST) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_LOAD;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, counter and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= {(AW+1){1'b0}};
      base_q  <= {AW{1'b0}};
      we_q    <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: DEPTH=32 and DEPTH=4 instances share directed
// stimulus and are checked every cycle against a behavioural model.
module tb_instr_encode_loader;
  import mips_isa_pkg::*;

`ifdef ENC_ILLEGAL_CHECK_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, in_valid;
  logic [4:0]  base_a;
  logic [1:0]  base_b;
  logic [3:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] adr;

  logic        rdy_a, we_a, done_a, err_a;
  logic [4:0]  addr_a;
  logic [31:0] wdata_a;
  logic [5:0]  count_a;
  logic        rdy_b, we_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  instr_encode_loader #(.DEPTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_a),
    .in_valid(in_valid), .in_ready(rdy_a), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm), .adr(adr), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .count(count_a), .done(done_a), .err(err_a)
  );

  instr_encode_loader #(.DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_b),
    .in_valid(in_valid), .in_ready(rdy_b), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm), .adr(adr), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .count(count_b), .done(done_b), .err(err_b)
  );

  logic [31:0] o_we[2], o_addr[2], o_wdata[2], o_count[2], o_done[2], o_err[2], o_rdy[2];
  assign o_we[0] = 32'(we_a);       assign o_we[1] = 32'(we_b);
  assign o_addr[0] = 32'(addr_a);   assign o_addr[1] = 32'(addr_b);
  assign o_wdata[0] = wdata_a;      assign o_wdata[1] = wdata_b;
  assign o_count[0] = 32'(count_a); assign o_count[1] = 32'(count_b);
  assign o_done[0] = 32'(done_a);   assign o_done[1] = 32'(done_b);
  assign o_err[0] = 32'(err_a);     assign o_err[1] = 32'(err_b);
  assign o_rdy[0] = 32'(rdy_a);     assign o_rdy[1] = 32'(rdy_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Encoding written as place-value arithmetic on the field values.
  function automatic bit [31:0] model_enc(input int o, input bit [31:0] s, t, d, sh, im, ad);
    bit [31:0] regs;
    regs = s * 32'd2097152 + t * 32'd65536;
    case (o)
      0: return regs + d * 32'd2048 + sh * 32'd64 + 32'h20;
      1: return regs + d * 32'd2048 + sh * 32'd64 + 32'h21;
      2: return regs + d * 32'd2048 + sh * 32'd64 + 32'h22;
      3: return regs + d * 32'd2048 + sh * 32'd64 + 32'h24;
      4: return 32'h08 * 32'd67108864 + regs + im;
      5: return 32'h23 * 32'd67108864 + regs + im;
      6: return 32'h2B * 32'd67108864 + regs + im;
      7: return 32'h04 * 32'd67108864 + regs + im;
      8: return 32'h02 * 32'd67108864 + ad;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int dep_of(input int i);
    return (i == 0) ? 32 : 4;
  endfunction

  int m_phase[2];   // 0 idle, 1 loading, 2 full
  int m_count[2], m_base[2], m_addr[2];
  bit [31:0] m_wdata[2];
  bit m_we[2], m_err[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] <= 0; m_count[i] <= 0; m_base[i] <= 0; m_addr[i] <= 0;
        m_wdata[i] <= 32'h0; m_we[i] <= 1'b0; m_err[i] <= 1'b0;
      end else begin
        m_we[i]  <= 1'b0;
        m_err[i] <= 1'b0;
        if (start) begin
          m_phase[i] <= 1;
          m_count[i] <= 0;
          m_base[i]  <= (i == 0) ? int'(base_a) : int'(base_b);
        end else if (in_valid && m_phase[i] == 1) begin
          if (ILLEGAL_EN && op > 4'd8) begin
            m_err[i] <= 1'b1;
          end else begin
            m_we[i]    <= 1'b1;
            m_addr[i]  <= (m_base[i] + m_count[i]) % dep_of(i);
            m_wdata[i] <= model_enc(int'(op), 32'(rs), 32'(rt), 32'(rd), 32'(shamt), 32'(imm), 32'(adr));
            m_count[i] <= m_count[i] + 1;
            if (m_count[i] + 1 == dep_of(i)) m_phase[i] <= 2;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc_we%0d", i), o_we[i], 32'(m_we[i]));
        chk($sformatf("cyc_addr%0d", i), o_addr[i], 32'(m_addr[i]));
        chk($sformatf("cyc_wdata%0d", i), o_wdata[i], m_wdata[i]);
        chk($sformatf("cyc_count%0d", i), o_count[i], 32'(m_count[i]));
        chk($sformatf("cyc_done%0d", i), o_done[i], 32'(m_phase[i] == 2));
        chk($sformatf("cyc_err%0d", i), o_err[i], 32'(m_err[i]));
        chk($sformatf("cyc_rdy%0d", i), o_rdy[i], 32'((m_phase[i] == 1) && !start));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input int s, t, d, sh, im, ad);
    op = o; rs = 5'(s); rt = 5'(t); rd = 5'(d); shamt = 5'(sh);
    imm = 16'(im); adr = 26'(ad); in_valid = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_we%0d", tag, i), o_we[i], 32'd0);
      chk($sformatf("%s_addr%0d", tag, i), o_addr[i], 32'd0);
      chk($sformatf("%s_wdata%0d", tag, i), o_wdata[i], 32'd0);
      chk($sformatf("%s_count%0d", tag, i), o_count[i], 32'd0);
      chk($sformatf("%s_done%0d", tag, i), o_done[i], 32'd0);
      chk($sformatf("%s_err%0d", tag, i), o_err[i], 32'd0);
      chk($sformatf("%s_rdy%0d", tag, i), o_rdy[i], 32'd0);
    end
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; base_a = 5'd0; base_b = 2'd0;
    op = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; imm = 16'd0; adr = 26'd0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    cmp_en = 1'b1;

    start = 1'b1; base_a = 5'h10; base_b = 2'd3;
    tick();
    start = 1'b0;
    #1;
    chk("ready_a_load", 32'(rdy_a), 32'd1);

    drive(OP_ADD, 1, 2, 3, 0, 0, 0); tick();
    chk("add_we", 32'(we_a), 32'd1);
    chk("add_addr", 32'(addr_a), 32'h10);
    chk("add_wdata", wdata_a, 32'h00221820);
    chk("add_addr_b", 32'(addr_b), 32'd3);

    drive(OP_ADDI, 1, 2, 0, 0, 5, 0); tick();
    chk("addi_wdata", wdata_a, 32'h20220005);
    chk("addi_addr_b_wrap", 32'(addr_b), 32'd0);

    drive(OP_LW, 29, 8, 0, 0, 4, 0); tick();
    chk("lw_wdata", wdata_a, 32'h8FA80004);
    chk("lw_addr_b", 32'(addr_b), 32'd1);

    drive(OP_BEQ, 1, 2, 0, 0, 16'hFFFF, 0); tick();
    chk("beq_wdata", wdata_a, 32'h1022FFFF);
    chk("beq_addr_b", 32'(addr_b), 32'd2);
    chk("full_done_b", 32'(done_b), 32'd1);
    chk("full_rdy_b", 32'(rdy_b), 32'd0);
    chk("full_count_b", 32'(count_b), 32'd4);

    drive(OP_J, 0, 0, 0, 0, 0, 26'h100); tick();
    chk("j_wdata", wdata_a, 32'h08000100);
    chk("j_addr", 32'(addr_a), 32'h14);
    chk("j_count", 32'(count_a), 32'd5);
    chk("full_no_we_b", 32'(we_b), 32'd0);

    in_valid = 1'b0; tick();
    chk("idle_we", 32'(we_a), 32'd0);
    chk("idle_hold", wdata_a, 32'h08000100);

    drive(4'd12, 1, 2, 3, 4, 5, 6); tick();
`ifdef ENC_ILLEGAL_CHECK_EN
    chk("illegal_err", 32'(err_a), 32'd1);
    chk("illegal_no_we", 32'(we_a), 32'd0);
    chk("illegal_count", 32'(count_a), 32'd5);
`else
    chk("illegal_err", 32'(err_a), 32'd0);
    chk("illegal_we", 32'(we_a), 32'd1);
    chk("illegal_wdata", wdata_a, 32'h00000000);
    chk("illegal_count", 32'(count_a), 32'd6);
`endif
    in_valid = 1'b0; tick();
    chk("err_pulse_end", 32'(err_a), 32'd0);

    start = 1'b1; base_a = 5'h1E; base_b = 2'd1;
    drive(OP_ADD, 4, 5, 6, 7, 0, 0); tick();
    start = 1'b0;
    chk("restart_no_we", 32'(we_a), 32'd0);
    chk("restart_count", 32'(count_a), 32'd0);
    chk("restart_count_b", 32'(count_b), 32'd0);
    tick();
    chk("restart_addr", 32'(addr_a), 32'h1E);
    chk("restart_wdata", wdata_a, 32'h008531E0);
    chk("restart_addr_b", 32'(addr_b), 32'd1);

    drive(OP_SW, 2, 3, 0, 0, 8, 0); tick();
    chk("sw_wdata", wdata_a, 32'hAC430008);
    chk("sw_addr", 32'(addr_a), 32'h1F);

    drive(OP_AND, 1, 1, 1, 0, 0, 0); tick();
    chk("and_wdata", wdata_a, 32'h00210824);
    chk("wrap_addr_a", 32'(addr_a), 32'd0);
    chk("count_b_3", 32'(count_b), 32'd3);

    drive(OP_ADDU, 0, 0, 0, 0, 0, 0); tick();
    chk("addu_we", 32'(we_a), 32'd1);
    chk("addu_wdata", wdata_a, 32'h00000021);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    chk("post_reset_we", 32'(we_a), 32'd0);
    chk("post_reset_count", 32'(count_a), 32'd0);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
